// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN shortens divide-by-zero, signed overflow and zero-operand multiplies.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned RW = XLEN + 1;
  localparam int unsigned SW = XLEN + 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]        r_fn, w_fn_nxt;
  logic [XLEN-1:0]   r_opa, w_opa_nxt;
  logic [XLEN-1:0]   r_opb, w_opb_nxt;
  logic [W2-1:0]     r_acc, w_acc_nxt;
  logic [RW-1:0]     r_rem, w_rem_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic              r_bzero, w_bzero_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;

  // Operand signedness and magnitudes at acceptance
  logic            w_sa, w_sb;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  assign w_sa    = A[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                (funct3 == 3'b100) | (funct3 == 3'b110));
  assign w_sb    = B[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110));
  assign w_mag_a = w_sa ? -A : A;
  assign w_mag_b = w_sb ? -B : B;

  // Multiply step: add multiplicand into the high half, shift the product right
  logic [XLEN:0] w_msum;
  assign w_msum = {1'b0, r_acc[W2-1:XLEN]} + (r_opb[0] ? {1'b0, r_opa} : RW'(0));

  // Restoring divide step: shift in next dividend bit, subtract if it fits
  logic [SW-1:0] w_shift;
  logic          w_ge;
  logic [RW-1:0] w_dsub;
  assign w_shift = {r_rem, r_opa[XLEN-1]};
  assign w_ge    = (w_shift >= SW'(r_opb));
  assign w_dsub  = w_shift[XLEN:0] - RW'(r_opb);

  // Sign correction and result selection
  logic [W2-1:0]   w_prod;
  logic [XLEN-1:0] w_qraw, w_quo, w_rraw, w_remv, w_res;
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_qraw = r_acc[XLEN-1:0];
  assign w_quo  = r_bzero ? '1 : (r_neg_q ? -w_qraw : w_qraw);
  assign w_rraw = r_rem[XLEN-1:0];
  assign w_remv = r_neg_r ? -w_rraw : w_rraw;
  assign w_res  = r_fn[2] ? (r_fn[1] ? w_remv : w_quo)
                          : ((r_fn[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[W2-1:XLEN]);

  logic w_step;
`ifdef MULDIV_EARLY_OUT_EN
  logic w_div0, w_ovf, w_mulz, w_early;
  logic r_skip, w_skip_nxt;
  assign w_div0  = funct3[2] & (B == '0);
  assign w_ovf   = ((funct3 == 3'b100) | (funct3 == 3'b110)) &
                   (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == '1);
  assign w_mulz  = ~funct3[2] & ((A == '0) | (B == '0));
  assign w_early = w_div0 | w_ovf | w_mulz;
  assign w_step  = ~r_skip;

  // Early-out ops spend a single idle cycle in CALC with iteration suppressed
  always_comb begin
    w_skip_nxt = r_skip;
    if (r_state == S_IDLE && start) w_skip_nxt = w_early;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_skip <= 1'b0;
    else        r_skip <= w_skip_nxt;
  end
`else
  assign w_step = 1'b1;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_fn_nxt     = r_fn;
    w_opa_nxt    = r_opa;
    w_opb_nxt    = r_opb;
    w_acc_nxt    = r_acc;
    w_rem_nxt    = r_rem;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_bzero_nxt  = r_bzero;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_state_nxt = S_CALC;
          w_cnt_nxt   = '0;
          w_fn_nxt    = funct3;
          w_opa_nxt   = w_mag_a;
          w_opb_nxt   = w_mag_b;
          w_acc_nxt   = '0;
          w_rem_nxt   = '0;
          w_neg_q_nxt = w_sa ^ w_sb;
          w_neg_r_nxt = w_sa;
          w_bzero_nxt = (B == '0);
          w_busy_nxt  = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
          if (w_early) begin
            w_cnt_nxt = CNT_W'(XLEN - 1);
            if (w_ovf)  w_acc_nxt = W2'(w_mag_a);
            if (w_div0) w_rem_nxt = RW'(w_mag_a);
          end
`endif
        end
      end
      S_CALC: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_step) begin
          if (r_fn[2]) begin
            w_rem_nxt = w_ge ? w_dsub : w_shift[XLEN:0];
            w_acc_nxt = {r_acc[W2-2:0], w_ge};
            w_opa_nxt = r_opa << 1;
          end else begin
            w_acc_nxt = {w_msum, r_acc[XLEN-1:1]};
            w_opb_nxt = r_opb >> 1;
          end
        end
        if (r_cnt == CNT_W'(XLEN - 1)) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        w_done_nxt   = 1'b1;
        w_result_nxt = w_res;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_fn     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fn     <= w_fn_nxt;
      r_opa    <= w_opa_nxt;
      r_opb    <= w_opb_nxt;
      r_acc    <= w_acc_nxt;
      r_rem    <= w_rem_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_bzero  <= w_bzero_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: XLEN=32 and XLEN=8 instances, directed vectors,
// latency measured from acceptance edge to done.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, busy, done;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;
  logic        s8_start, s8_busy, s8_done;
  logic [2:0]  s8_funct3;
  logic [7:0]  s8_a, s8_b, s8_result;

  muldiv_unit #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .A(a), .B(b),
    .busy(busy), .done(done), .result(result));

  muldiv_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .funct3(s8_funct3), .A(s8_a), .B(s8_b),
    .busy(s8_busy), .done(s8_done), .result(s8_result));

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last32 = '0;
  logic [7:0]  last8 = '0;
  exp_t e32, e8;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q32.size() == 0) begin
          chk("spurious_done32", 32'd1, 32'd0);
        end else begin
          e32 = q32.pop_front();
          chk({e32.name, "_result"}, result, e32.res);
          chk({e32.name, "_latency"}, 32'(cyc - e32.acc_cyc), 32'(e32.lat));
          chk({e32.name, "_busy_at_done"}, 32'(busy), 32'd1);
          last32 = result;
        end
      end else begin
        chk("result32_stable", result, last32);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (s8_done) begin
        if (q8.size() == 0) begin
          chk("spurious_done8", 32'd1, 32'd0);
        end else begin
          e8 = q8.pop_front();
          chk({e8.name, "_result"}, 32'(s8_result), e8.res);
          chk({e8.name, "_latency"}, 32'(cyc - e8.acc_cyc), 32'(e8.lat));
          last8 = s8_result;
        end
      end else begin
        chk("result8_stable", 32'(s8_result), 32'(last8));
      end
    end
  end

  task automatic wait_done32(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic op32(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] exp_res, input bit eo_case, input string nm);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = av; b = bv;
    @(posedge clk); #1;
    q32.push_back('{exp_res, cyc, (eo_case && EO) ? 2 : 33, nm});
    start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
    chk({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
    wait_done32(nm);
  endtask

  task automatic op8(input logic [2:0] f, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] exp_res, input bit eo_case, input string nm);
    bit seen = 1'b0;
    @(negedge clk);
    s8_start = 1'b1; s8_funct3 = f; s8_a = av; s8_b = bv;
    @(posedge clk); #1;
    q8.push_back('{32'(exp_res), cyc, (eo_case && EO) ? 2 : 9, nm});
    s8_start = 1'b0; s8_funct3 = 3'($urandom); s8_a = 8'($urandom); s8_b = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s8_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int ndone;
    rst_n = 1'b0; start = 1'b0; funct3 = '0; a = '0; b = '0;
    s8_start = 1'b0; s8_funct3 = '0; s8_a = '0; s8_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy32", 32'(busy), 32'd0);
    chk("reset_done32", 32'(done), 32'd0);
    chk("reset_result32", result, 32'd0);
    chk("reset_busy8", 32'(s8_busy), 32'd0);
    chk("reset_done8", 32'(s8_done), 32'd0);
    chk("reset_result8", 32'(s8_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op32(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
    op32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh_m1_m1");
    op32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
    op32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1_max");
    op32(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_min");
    op32(3'b000, 32'd0,         32'd5,         32'd0,         1'b1, "mul_zero");
    op32(3'b011, 32'h1234_5678, 32'd0,         32'd0,         1'b1, "mulhu_zero");
    op32(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
    op32(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2");
    op32(3'b101, 32'd100,       32'd7,         32'd14,        1'b0, "divu_100_7");
    op32(3'b111, 32'd100,       32'd7,         32'd2,         1'b0, "remu_100_7");
    op32(3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, "div_20_m3");
    op32(3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         1'b0, "rem_20_m3");
    op32(3'b101, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1'b1, "divu_by0");
    op32(3'b110, 32'h1234,      32'd0,         32'h1234,      1'b1, "rem_by0");
    op32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
    op32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "rem_ovf");
    op32(3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1, "div_m5_by0");
    op32(3'b111, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1, "remu_by0");

    // start held high: accepted only every XLEN+2 cycles
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    n0 = cyc;
    for (int k = 0; k < 3; k++) q32.push_back('{32'd12, n0 + k * 34, 33, "held_start"});
    ndone = 0;
    for (int i = 0; i < 200 && ndone < 3; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_start_count", 32'(ndone), 32'd3);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_busy", 32'(busy), 32'd0);
    chk("midop_reset_done", 32'(done), 32'd0);
    chk("midop_reset_result", result, 32'd0);
    q32.delete();
    last32 = '0;
    last8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op32(3'b000, 32'd5, 32'd5, 32'h0000_0019, 1'b0, "mul_after_reset");

    op8(3'b011, 8'hFF, 8'hFF, 8'hFE, 1'b0, "x8_mulhu_max");
    op8(3'b100, 8'h80, 8'hFF, 8'h80, 1'b1, "x8_div_ovf");
    op8(3'b110, 8'h80, 8'hFF, 8'h00, 1'b1, "x8_rem_ovf");
    op8(3'b000, 8'h0F, 8'h11, 8'hFF, 1'b0, "x8_mul");
    op8(3'b101, 8'd200, 8'd13, 8'd15, 1'b0, "x8_divu");
    op8(3'b111, 8'd200, 8'd13, 8'd5, 1'b0, "x8_remu");
    op8(3'b001, 8'h80, 8'h7F, 8'hC0, 1'b0, "x8_mulh");

    repeat (5) @(negedge clk);
    chk("q32_drained", 32'(q32.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
